// File: rtl/bin2bcd_scan.sv
// Binary-to-BCD converter (shift-add-3) with a free-running digit-scan counter.
// Latency: start sampled at edge N -> busy high after edges N..N+13, done/bcd updated at edge N+15.
// Backpressure: none; start is ignored while a conversion is in flight, no queuing.
//
// Ports:
//   clk      - single clock, rising edge
//   rst      - asynchronous active-high reset
//   bin      - 14-bit unsigned value to convert (0..16383)
//   start    - conversion request, sampled only when the converter is idle
//   bcd      - packed 4-digit result {thousands, hundreds, tens, ones}
//   counter  - digit-select scan count (0 = ones .. 3 = thousands)
//   busy     - high while the shift sequence runs
//   done     - one-cycle pulse when bcd takes a new result
//   ovf      - last converted value exceeded 9999
//
// Optional build macro BIN2BCD_SAT_EN: when defined, an overflowing result
// clamps bcd to 9999; otherwise bcd shows the value modulo 10000.

module bin2bcd_scan #(
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] bin,
    input  logic        start,
    output logic [15:0] bcd,
    output logic [1:0]  counter,
    output logic        busy,
    output logic        done,
    output logic        ovf
);

    // ------------------------------------------------------------------
    // Scan prescaler: free-running, independent of the converter.
    // ------------------------------------------------------------------
    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);

    logic [PW-1:0] prescale;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescale <= '0;
            counter  <= 2'd0;
        end else if (prescale == PRE_LAST) begin
            prescale <= '0;
            counter  <= counter + 2'd1;
        end else begin
            prescale <= prescale + PW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Converter FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    logic [13:0] shreg;
    logic [19:0] acc;
    logic [3:0]  iter;
    logic [19:0] acc_adj;

    // Add-3 correction on every digit >= 5 before the shift, so each digit
    // carries correctly into the next decade after doubling.
    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < 5; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            shreg <= 14'd0;
            acc   <= 20'd0;
            iter  <= 4'd0;
            bcd   <= 16'h0000;
            busy  <= 1'b0;
            done  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg <= bin;
                        acc   <= 20'd0;
                        iter  <= 4'd14;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc   <= {acc_adj[18:0], shreg[13]};
                    shreg <= {shreg[12:0], 1'b0};
                    iter  <= iter - 4'd1;
                    // Last shift: busy drops together with the move to DONE.
                    if (iter == 4'd1) begin
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    // bcd is only written here, so the display never sees a
                    // partially shifted accumulator.
                    ovf <= (acc[19:16] != 4'd0);
`ifdef BIN2BCD_SAT_EN
                    bcd <= (acc[19:16] != 4'd0) ? 16'h9999 : acc[15:0];
`else
                    bcd <= acc[15:0];
`endif
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_scan.sv
// Testbench for bin2bcd_scan: scoreboard of expected results fed by a
// reference model at stimulus time, checked by an independent monitor.
// Scan counter and busy window are predicted from cycle arithmetic.

module tb_bin2bcd_scan;

    localparam int unsigned SCAN_DIV = 4;

    logic        clk;
    logic        rst;
    logic [13:0] bin;
    logic        start;
    logic [15:0] bcd;
    logic [1:0]  counter;
    logic        busy;
    logic        done;
    logic        ovf;

    bin2bcd_scan #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk     (clk),
        .rst     (rst),
        .bin     (bin),
        .start   (start),
        .bcd     (bcd),
        .counter (counter),
        .busy    (busy),
        .done    (done),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain decimal arithmetic on the integer value.
    function automatic logic [16:0] ref_conv(input int v);
        int          d;
        logic [15:0] b;
        logic        o;
        o = (v > 9999);
        d = v % 10000;
        b = 16'((d / 1000) * 4096 + ((d / 100) % 10) * 256 + ((d / 10) % 10) * 16 + (d % 10));
`ifdef BIN2BCD_SAT_EN
        if (o) b = 16'h9999;
`endif
        return {o, b};
    endfunction

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          cyc       = 0;   // edges seen since time 0 (out of reset)
    int          k         = 0;   // edges since reset release, for scan model
    bit          have_acc  = 0;
    int          acc_edge  = 0;
    logic [15:0] shown_bcd = 16'h0000;
    logic        shown_ovf = 1'b0;

    always @(posedge rst) begin
        sb.delete();
        have_acc  = 0;
        k         = 0;
        shown_bcd = 16'h0000;
        shown_ovf = 1'b0;
    end

    // Stimulus-side model: decide whether this edge accepts start.
    always @(posedge clk) begin
        if (rst) begin
            k = 0;
            have_acc = 0;
        end else begin
            logic [16:0] r;
            exp_t        e;
            cyc++;
            k++;
            if (start && (!have_acc || cyc >= acc_edge + 16)) begin
                have_acc = 1;
                acc_edge = cyc;
                r     = ref_conv(int'(bin));
                e.bcd = r[15:0];
                e.ovf = r[16];
                e.cyc = cyc + 15;
                sb.push_back(e);
            end
        end
    end

    // Monitor: compare DUT outputs against the model away from the clock edge.
    always @(negedge clk) begin
        if (!rst) begin
            logic exp_done;
            logic exp_busy;
            exp_busy = have_acc && (cyc - acc_edge) <= 13;
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("counter", 32'(counter), 32'((k / SCAN_DIV) % 4));
            exp_done = (sb.size() > 0) && (sb[0].cyc == cyc);
            chk("done", 32'(done), 32'(exp_done));
            if (exp_done) begin
                shown_bcd = sb[0].bcd;
                shown_ovf = sb[0].ovf;
                void'(sb.pop_front());
            end
            chk("bcd", 32'(bcd), 32'(shown_bcd));
            chk("ovf", 32'(ovf), 32'(shown_ovf));
        end
    end

    task automatic convert(input logic [13:0] v);
        @(negedge clk);
        bin   = v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (16) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        bin   = 14'd0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_bcd", 32'(bcd), 32'h0);
        chk("reset_counter", 32'(counter), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        chk("reset_ovf", 32'(ovf), 32'h0);
        rst = 1'b0;

        // 1234 with a second start at busy cycle 5 that must be ignored.
        @(negedge clk);
        bin   = 14'd1234;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        bin   = 14'd42;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bin   = 14'd0;
        repeat (16) @(negedge clk);

        // Boundary values.
        convert(14'd0);
        convert(14'd9999);
        convert(14'd10000);
        convert(14'd16383);
        convert(14'd1);

        // Start held high: back-to-back conversions at each idle cycle.
        @(negedge clk);
        bin   = 14'd777;
        start = 1'b1;
        repeat (40) @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);

        // Random values with random idle gaps.
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            convert(14'($urandom_range(0, 16383)));
        end

        // Abort mid-conversion: outputs clear immediately, no done follows.
        @(negedge clk);
        bin   = 14'd4321;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_bcd", 32'(bcd), 32'h0);
        chk("abort_counter", 32'(counter), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_done", 32'(done), 32'h0);
        chk("abort_ovf", 32'(ovf), 32'h0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        repeat (20) @(negedge clk);

        convert(14'd5678);
        repeat (10) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
